// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of all signals between mem_arbiter and its users:
//                the CPU and program-loader request ports and the
//                asynchronous SRAM bus.
//                slave  modport : arbiter side (takes requests, drives SRAM)
//                master modport : environment side (requesters and SRAM)
//                Ports:
//                  cpu_*/ldr_* : req, we, addr[19:0], wdata[15:0] in;
//                                rdata[15:0], done out (arbiter view)
//                  Mem_CE/UB/LB/OE/WE : active-low SRAM strobes
//                  ADDR[19:0], Data_out[15:0], Data_oe : SRAM address/write
//                  Data_in[15:0] : SRAM read bus
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
    // CPU requester
    logic        cpu_req;
    logic        cpu_we;
    logic [19:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_done;
    // Program-loader requester
    logic        ldr_req;
    logic        ldr_we;
    logic [19:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic [15:0] ldr_rdata;
    logic        ldr_done;
    // SRAM side
    logic        Mem_CE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [19:0] ADDR;
    logic [15:0] Data_in;
    logic [15:0] Data_out;
    logic        Data_oe;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_done,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        output ADDR, Data_out, Data_oe,
        input  Data_in
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_done,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        input  ADDR, Data_out, Data_oe,
        output Data_in
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (CPU / program loader) arbiter in front of an
//                asynchronous 16-bit SRAM. Each transaction runs
//                IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE with
//                all SRAM strobes registered.
//                Ports:
//                  Clk   : system clock, rising edge
//                  Reset : synchronous, active-high
//                  bus   : mem_arbiter_if.slave (requesters + SRAM bus)
//                Parameter:
//                  WAIT_CYCLES : ACCESS cycles per transaction, 1..15
//                Build option:
//                  MEM_ARB_RR_EN defined   -> round-robin on simultaneous
//                                             requests (CPU first after reset)
//                  MEM_ARB_RR_EN undefined -> CPU has fixed priority
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_sel_cpu;     // winner of the current transaction
    logic        r_we;          // latched direction of the current transaction
    logic        r_mem_ce;      // shared by CE, UB and LB
    logic        r_mem_oe;
    logic        r_mem_we;
    logic [19:0] r_addr;
    logic [15:0] r_data_out;
    logic        r_data_oe;
    logic        r_cpu_done;
    logic        r_ldr_done;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_ldr_rdata;

    logic        w_any_req;
    logic        w_pick_cpu;
    logic        w_win_we;
    logic [19:0] w_win_addr;
    logic [15:0] w_win_wdata;

    assign w_any_req = bus.cpu_req | bus.ldr_req;

`ifdef MEM_ARB_RR_EN
    logic r_last_cpu;           // 1: CPU was granted last, 0: loader

    // On a tie the port that did not win last time is served.
    assign w_pick_cpu = bus.cpu_req & (~bus.ldr_req | ~r_last_cpu);
`else
    assign w_pick_cpu = bus.cpu_req;
`endif

    assign w_win_we    = w_pick_cpu ? bus.cpu_we    : bus.ldr_we;
    assign w_win_addr  = w_pick_cpu ? bus.cpu_addr  : bus.ldr_addr;
    assign w_win_wdata = w_pick_cpu ? bus.cpu_wdata : bus.ldr_wdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_sel_cpu   <= 1'b0;
            r_we        <= 1'b0;
            r_mem_ce    <= 1'b1;
            r_mem_oe    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_addr      <= 20'd0;
            r_data_out  <= 16'd0;
            r_data_oe   <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_ldr_done  <= 1'b0;
            r_cpu_rdata <= 16'd0;
            r_ldr_rdata <= 16'd0;
`ifdef MEM_ARB_RR_EN
            r_last_cpu  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // Everything the transaction needs is captured here,
                        // so requester inputs are don't-care until DONE.
                        r_state    <= S_SETUP;
                        r_sel_cpu  <= w_pick_cpu;
                        r_we       <= w_win_we;
                        r_addr     <= w_win_addr;
                        r_data_out <= w_win_we ? w_win_wdata : 16'd0;
                        r_data_oe  <= w_win_we;
                        r_mem_ce   <= 1'b0;
                        r_mem_oe   <= w_win_we;
`ifdef MEM_ARB_RR_EN
                        r_last_cpu <= w_pick_cpu;
`endif
                    end
                end
                S_SETUP: begin
                    r_state    <= S_ACCESS;
                    r_wait_cnt <= c_wait_load;
                    r_mem_we   <= ~r_we;
                end
                S_ACCESS: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state  <= S_DONE;
                        r_mem_ce <= 1'b1;
                        r_mem_oe <= 1'b1;
                        r_mem_we <= 1'b1;
                        if (!r_we) begin
                            if (r_sel_cpu) begin
                                r_cpu_rdata <= bus.Data_in;
                            end else begin
                                r_ldr_rdata <= bus.Data_in;
                            end
                        end
                        r_cpu_done <= r_sel_cpu;
                        r_ldr_done <= ~r_sel_cpu;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_cpu_done <= 1'b0;
                    r_ldr_done <= 1'b0;
                    r_data_oe  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Mem_CE    = r_mem_ce;
    assign bus.Mem_UB    = r_mem_ce;
    assign bus.Mem_LB    = r_mem_ce;
    assign bus.Mem_OE    = r_mem_oe;
    assign bus.Mem_WE    = r_mem_we;
    assign bus.ADDR      = r_addr;
    assign bus.Data_out  = r_data_out;
    assign bus.Data_oe   = r_data_oe;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.ldr_done  = r_ldr_done;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ldr_rdata = r_ldr_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. dut0 uses
//                WAIT_CYCLES=2, dut1 uses WAIT_CYCLES=1. Cycle 0 is the
//                period in which a request is first presented; outputs are
//                sampled 1 time unit after each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic Clk = 1'b0;
    logic Reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 Clk = ~Clk;

    mem_arbiter_if bus0 ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.WAIT_CYCLES(2)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
        bus0.ldr_req = 0; bus0.ldr_we = 0; bus0.ldr_addr = '0; bus0.ldr_wdata = '0;
        bus0.Data_in = '0;
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.ldr_req = 0; bus1.ldr_we = 0; bus1.ldr_addr = '0; bus1.ldr_wdata = '0;
        bus1.Data_in = '0;
    endtask

    task automatic test_reset();
        logic [4:0] strobes;
        idle_inputs();
        Reset = 1'b1;
        repeat (2) next_cycle();
        strobes = {bus0.Mem_CE, bus0.Mem_UB, bus0.Mem_LB, bus0.Mem_OE, bus0.Mem_WE};
        tests_run++;
        if (strobes !== 5'b11111) begin
            tests_failed++; $display("FAIL reset_strobes: got %b expected 11111", strobes);
        end
        tests_run++;
        if (bus0.ADDR !== 20'd0 || bus0.Data_out !== 16'd0 || bus0.Data_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_bus: got ADDR=%h Data_out=%h Data_oe=%b expected 0/0/0",
                     bus0.ADDR, bus0.Data_out, bus0.Data_oe);
        end
        tests_run++;
        if (bus0.cpu_done !== 1'b0 || bus0.ldr_done !== 1'b0 ||
            bus0.cpu_rdata !== 16'd0 || bus0.ldr_rdata !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_ports: got done=%b%b rdata=%h/%h expected 00 0000/0000",
                     bus0.cpu_done, bus0.ldr_done, bus0.cpu_rdata, bus0.ldr_rdata);
        end
        tests_run++;
        if (bus1.Mem_CE !== 1'b1 || bus1.Mem_WE !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_dut1: got CE=%b WE=%b expected 1/1", bus1.Mem_CE, bus1.Mem_WE);
        end
        Reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = 20'h00010;
        bus0.Data_in = 16'h1234;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 4) bus0.Data_in = 16'hDEAD;
            if (c == 5) bus0.cpu_req = 0;
            tests_run++;
            if (bus0.Mem_OE !== (c > 3)) begin
                tests_failed++;
                $display("FAIL read_oe cycle %0d: got %b expected %b", c, bus0.Mem_OE, c > 3);
            end
            tests_run++;
            if (bus0.Mem_CE !== (c > 3) || bus0.Mem_UB !== (c > 3) || bus0.Mem_LB !== (c > 3)) begin
                tests_failed++;
                $display("FAIL read_ce cycle %0d: got %b%b%b expected all %b",
                         c, bus0.Mem_CE, bus0.Mem_UB, bus0.Mem_LB, c > 3);
            end
            tests_run++;
            if (bus0.cpu_done !== (c == 4) || bus0.ldr_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL read_done cycle %0d: got cpu=%b ldr=%b expected cpu=%b ldr=0",
                         c, bus0.cpu_done, bus0.ldr_done, c == 4);
            end
        end
        tests_run++;
        if (bus0.cpu_rdata !== 16'h1234 || bus0.ldr_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL read_rdata: got cpu=%h ldr=%h expected 1234/0000",
                     bus0.cpu_rdata, bus0.ldr_rdata);
        end
    endtask

    task automatic test_ldr_write();
        int we_low = 0;
        bus0.ldr_req = 1; bus0.ldr_we = 1; bus0.ldr_addr = 20'h0FFFF; bus0.ldr_wdata = 16'hBEEF;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            // Drop the request and scramble inputs mid-flight: must not matter.
            if (c == 2) begin
                bus0.ldr_req = 0; bus0.ldr_we = 0; bus0.ldr_wdata = 16'h0000;
            end
            if (bus0.Mem_WE === 1'b0) we_low++;
            tests_run++;
            if (bus0.Mem_WE !== !(c == 2 || c == 3)) begin
                tests_failed++;
                $display("FAIL write_we cycle %0d: got %b expected %b", c, bus0.Mem_WE, !(c == 2 || c == 3));
            end
            tests_run++;
            if (bus0.Data_oe !== (c <= 4)) begin
                tests_failed++;
                $display("FAIL write_data_oe cycle %0d: got %b expected %b", c, bus0.Data_oe, c <= 4);
            end
            if (c <= 4) begin
                tests_run++;
                if (bus0.Data_out !== 16'hBEEF || bus0.ADDR !== 20'h0FFFF) begin
                    tests_failed++;
                    $display("FAIL write_bus cycle %0d: got Data_out=%h ADDR=%h expected BEEF/0FFFF",
                             c, bus0.Data_out, bus0.ADDR);
                end
            end
            tests_run++;
            if (bus0.Mem_OE !== 1'b1) begin
                tests_failed++;
                $display("FAIL write_oe cycle %0d: got %b expected 1", c, bus0.Mem_OE);
            end
            tests_run++;
            if (bus0.ldr_done !== (c == 4) || bus0.cpu_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL write_done cycle %0d: got ldr=%b cpu=%b expected ldr=%b cpu=0",
                         c, bus0.ldr_done, bus0.cpu_done, c == 4);
            end
        end
        tests_run++;
        if (we_low != 2) begin
            tests_failed++; $display("FAIL write_we_count: got %0d expected 2", we_low);
        end
        tests_run++;
        if (bus0.cpu_rdata !== 16'h1234 || bus0.ldr_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL write_rdata_hold: got cpu=%h ldr=%h expected 1234/0000",
                     bus0.cpu_rdata, bus0.ldr_rdata);
        end
    endtask

    task automatic test_addr_hold();
        bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = 20'h00010; bus0.Data_in = 16'h5555;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 2) bus0.cpu_addr = 20'h00020;
            if (c == 5) bus0.cpu_req = 0;
            if (c <= 4) begin
                tests_run++;
                if (bus0.ADDR !== 20'h00010) begin
                    tests_failed++;
                    $display("FAIL addr_hold cycle %0d: got %h expected 00010", c, bus0.ADDR);
                end
            end
            tests_run++;
            if (bus0.cpu_done !== (c == 4)) begin
                tests_failed++;
                $display("FAIL addr_hold_done cycle %0d: got %b expected %b", c, bus0.cpu_done, c == 4);
            end
        end
        tests_run++;
        if (bus0.cpu_rdata !== 16'h5555) begin
            tests_failed++; $display("FAIL addr_hold_rdata: got %h expected 5555", bus0.cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_write();
        bus0.cpu_req = 1; bus0.cpu_we = 1; bus0.cpu_addr = 20'h00300; bus0.cpu_wdata = 16'hA5A5;
        for (int c = 1; c <= 3; c++) next_cycle();
        tests_run++;
        if (bus0.Mem_WE !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_access_we: got %b expected 0", bus0.Mem_WE);
        end
        Reset = 1'b1;
        next_cycle();
        Reset = 1'b0;
        bus0.cpu_req = 0;
        tests_run++;
        if (bus0.Mem_WE !== 1'b1 || bus0.Mem_CE !== 1'b1 || bus0.Data_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_strobes: got WE=%b CE=%b Data_oe=%b expected 1/1/0",
                     bus0.Mem_WE, bus0.Mem_CE, bus0.Data_oe);
        end
        tests_run++;
        if (bus0.cpu_rdata !== 16'd0) begin
            tests_failed++; $display("FAIL rst_mid_rdata: got %h expected 0000", bus0.cpu_rdata);
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (bus0.cpu_done !== 1'b0 || bus0.ldr_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_no_done step %0d: got cpu=%b ldr=%b expected 0/0",
                         c, bus0.cpu_done, bus0.ldr_done);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic exp_cpu, exp_ldr;
        bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = 20'h00100;
        bus0.ldr_req = 1; bus0.ldr_we = 0; bus0.ldr_addr = 20'h00200;
        bus0.Data_in = 16'h1000;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            bus0.Data_in = 16'h1000 + 16'(c / 5);
            if (c == 20) begin
                bus0.cpu_req = 0; bus0.ldr_req = 0;
            end
            exp_cpu = (c % 5 == 4) && (!RR || ((c / 5) % 2 == 0));
            exp_ldr = (c % 5 == 4) && RR && ((c / 5) % 2 == 1);
            tests_run++;
            if (bus0.cpu_done !== exp_cpu || bus0.ldr_done !== exp_ldr) begin
                tests_failed++;
                $display("FAIL b2b_done cycle %0d: got cpu=%b ldr=%b expected cpu=%b ldr=%b",
                         c, bus0.cpu_done, bus0.ldr_done, exp_cpu, exp_ldr);
            end
        end
        tests_run++;
        if (RR) begin
            if (bus0.cpu_rdata !== 16'h1002 || bus0.ldr_rdata !== 16'h1003) begin
                tests_failed++;
                $display("FAIL b2b_rdata: got cpu=%h ldr=%h expected 1002/1003",
                         bus0.cpu_rdata, bus0.ldr_rdata);
            end
        end else begin
            if (bus0.cpu_rdata !== 16'h1003 || bus0.ldr_rdata !== 16'h0000) begin
                tests_failed++;
                $display("FAIL b2b_rdata: got cpu=%h ldr=%h expected 1003/0000",
                         bus0.cpu_rdata, bus0.ldr_rdata);
            end
        end
    endtask

    task automatic test_wait1();
        logic exp_ce;
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 20'h00042; bus1.Data_in = 16'h0777;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == 6) bus1.cpu_req = 0;
            exp_ce = !(c == 1 || c == 2 || c == 5 || c == 6);
            tests_run++;
            if (bus1.Mem_CE !== exp_ce) begin
                tests_failed++;
                $display("FAIL w1_ce cycle %0d: got %b expected %b", c, bus1.Mem_CE, exp_ce);
            end
            tests_run++;
            if (bus1.cpu_done !== (c == 3 || c == 7)) begin
                tests_failed++;
                $display("FAIL w1_done cycle %0d: got %b expected %b", c, bus1.cpu_done, c == 3 || c == 7);
            end
        end
        tests_run++;
        if (bus1.cpu_rdata !== 16'h0777) begin
            tests_failed++; $display("FAIL w1_rdata: got %h expected 0777", bus1.cpu_rdata);
        end
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_addr_hold();
        test_reset_mid_write();
        test_reset();
        test_back_to_back();
        test_wait1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
